// File: rtl/ir_fetch_ctrl_pkg.sv
// Shared LC-3b types for the instruction-fetch controller: data words, opcode,
// fetch state encoding and the PC increment.
package ir_fetch_ctrl_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [3:0]  lc3b_opcode;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN
   } lc3b_fetch_state;

   localparam lc3b_word LC3B_PC_STEP = 16'd2;

   // Instruction addresses are always word aligned.
   function automatic lc3b_word align_pc(input lc3b_word a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/ir_fetch_ctrl_if.sv
// Fetch controller bus: memory read handshake, IR valid/ready handshake to the
// consumer, and the control-flow redirect request.
interface ir_fetch_ctrl_if;
   import ir_fetch_ctrl_pkg::*;

   lc3b_word   mem_address;
   logic       mem_read;
   logic       mem_resp;
   lc3b_word   mem_rdata;
   lc3b_word   ir_out;
   lc3b_opcode ir_opcode;
   lc3b_word   ir_pc;
   logic       ir_valid;
   logic       ir_ready;
   logic       redirect;
   lc3b_word   redirect_pc;

   modport master (
      output mem_address, mem_read, ir_out, ir_opcode, ir_pc, ir_valid,
      input  mem_resp, mem_rdata, ir_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_address, mem_read, ir_out, ir_opcode, ir_pc, ir_valid,
      output mem_resp, mem_rdata, ir_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/ir_fetch_ctrl_fetch_buf.sv
// One instruction entry: word, fetch address and valid flag. Load wins over
// clear when both are requested in the same cycle.
module fetch_buf
   import ir_fetch_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     clear,
   input  lc3b_word load_word,
   input  lc3b_word load_pc,
   output lc3b_word word,
   output lc3b_word pc,
   output logic     valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         word  <= '0;
         pc    <= '0;
         valid <= 1'b0;
      end else if (load) begin
         word  <= load_word;
         pc    <= load_pc;
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// LC-3b instruction-fetch controller: sequences reads at pc, holds the IR for the
// consumer and drains reads abandoned by a redirect. IR_PREFETCH_EN adds a one-entry prefetch buffer.
module ir_fetch_ctrl
   import ir_fetch_ctrl_pkg::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000
) (
   input  logic            clk,
   input  logic            rst,
   ir_fetch_ctrl_if.master bus
);

   localparam lc3b_word START_PC = RESET_PC & 16'hFFFE;

   lc3b_fetch_state state, state_next;
   lc3b_word        pc, pc_next;
   lc3b_word        drain_addr, drain_next;
   lc3b_word        new_pc;
   logic            accept;

   logic            ir_load, ir_clear, ir_valid;
   lc3b_word        ir_word, ir_pc, ld_word, ld_pc;

`ifdef IR_PREFETCH_EN
   logic            pf_load, pf_clear, pf_valid;
   lc3b_word        pf_word, pf_pc;
`endif

   assign new_pc = align_pc(bus.redirect_pc);
   assign accept = ir_valid & bus.ir_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= START_PC;
         drain_addr <= START_PC;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         drain_addr <= drain_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      drain_next = drain_addr;
      ir_load    = 1'b0;
      ir_clear   = 1'b0;
      ld_word    = bus.mem_rdata;
      ld_pc      = pc;
`ifdef IR_PREFETCH_EN
      pf_load    = 1'b0;
      pf_clear   = 1'b0;
`endif
      case (state)
         FETCH: begin
            if (bus.redirect) begin
               pc_next = new_pc;
               // A request cannot be withdrawn, so keep its address until it completes.
               if (!bus.mem_resp) begin
                  state_next = DRAIN;
                  drain_next = pc;
               end
            end else if (bus.mem_resp) begin
               ir_load    = 1'b1;
               pc_next    = pc + LC3B_PC_STEP;
               state_next = HOLD;
            end
         end
         DRAIN: begin
            if (bus.redirect) pc_next = new_pc;
            if (bus.mem_resp) state_next = FETCH;
         end
         HOLD: begin
`ifdef IR_PREFETCH_EN
            if (bus.redirect) begin
               ir_clear   = 1'b1;
               pf_clear   = 1'b1;
               pc_next    = new_pc;
               state_next = FETCH;
               // An empty buffer means a prefetch read is on the bus.
               if (!pf_valid && !bus.mem_resp) begin
                  state_next = DRAIN;
                  drain_next = pc;
               end
            end else if (accept) begin
               if (pf_valid) begin
                  ir_load  = 1'b1;
                  ld_word  = pf_word;
                  ld_pc    = pf_pc;
                  pf_clear = 1'b1;
               end else if (bus.mem_resp) begin
                  ir_load = 1'b1;
                  pc_next = pc + LC3B_PC_STEP;
               end else begin
                  ir_clear   = 1'b1;
                  state_next = FETCH;
               end
            end else if (bus.mem_resp && !pf_valid) begin
               pf_load = 1'b1;
               pc_next = pc + LC3B_PC_STEP;
            end
`else
            if (bus.redirect) begin
               ir_clear   = 1'b1;
               pc_next    = new_pc;
               state_next = FETCH;
            end else if (accept) begin
               ir_clear   = 1'b1;
               state_next = FETCH;
            end
`endif
         end
         default: state_next = FETCH;
      endcase
   end

   fetch_buf ir_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (ir_load),
      .clear     (ir_clear),
      .load_word (ld_word),
      .load_pc   (ld_pc),
      .word      (ir_word),
      .pc        (ir_pc),
      .valid     (ir_valid)
   );

`ifdef IR_PREFETCH_EN
   fetch_buf pf_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (pf_load),
      .clear     (pf_clear),
      .load_word (bus.mem_rdata),
      .load_pc   (pc),
      .word      (pf_word),
      .pc        (pf_pc),
      .valid     (pf_valid)
   );

   assign bus.mem_read = ~rst & ((state != HOLD) | ~pf_valid);
`else
   assign bus.mem_read = ~rst & (state != HOLD);
`endif

   assign bus.mem_address = (state == DRAIN) ? drain_addr : pc;
   assign bus.ir_out      = ir_word;
   assign bus.ir_opcode   = ir_word[15:12];
   assign bus.ir_pc       = ir_pc;
   assign bus.ir_valid    = ir_valid;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Bench for ir_fetch_ctrl: memory responder, directed and random stimulus, and a
// scoreboard holding the instruction stream the consumer must see.
module tb_ir_fetch_ctrl;
   import ir_fetch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ir_fetch_ctrl_if bus ();

   ir_fetch_ctrl #(.RESET_PC(16'h3000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   lc3b_word exp_q[$];
   lc3b_word req_log[$];
   int       mem_lat = 2;
   bit       mem_busy;
   int       mem_cnt;
   int       cur_lat;
   lc3b_word mem_addr_r;
   lc3b_word resp_addr;
   bit       lat_chk_en;

   bit       rst_d, acc_d, resp_d, vld_d, redir_d;
   lc3b_word raddr_d;

   function automatic lc3b_word memf(input lc3b_word a);
      lc3b_word t;
      t = a * 16'h9E37;
      return t ^ 16'h5AC3;
   endfunction

   task automatic chk16(input string name, input lc3b_word act, input lc3b_word exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, got no event, expected one within bound at %0t", name, $time);
   endtask

   // Expected instruction stream: sequential word addresses from a start point.
   task automatic push_stream(input lc3b_word start);
      lc3b_word p;
      exp_q.delete();
      p = start & 16'hFFFE;
      for (int i = 0; i < 1024; i++) begin
         exp_q.push_back(p);
         p = p + 16'd2;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic bit cond(input int mode);
      case (mode)
         0: return bus.ir_valid;
         1: return bus.mem_read && mem_busy && (mem_cnt == 1);
         2: return bus.mem_resp;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int mode, input string name);
      int k;
      k = 0;
      while (!cond(mode) && k < 100) begin
         cyc();
         k++;
      end
      if (!cond(mode)) timeout(name);
   endtask

   task automatic wait_reqs(input int n, input string name);
      int k;
      k = 0;
      while (req_log.size() < n && k < 100) begin
         cyc();
         k++;
      end
      if (req_log.size() < n) timeout(name);
   endtask

   // Memory: responds cur_lat cycles after the first cycle of each request.
   initial begin
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      mem_busy      = 1'b0;
      mem_cnt       = 0;
      cur_lat       = 1;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_resp = 1'b0;
         if (rst) begin
            mem_busy = 1'b0;
         end else if (bus.mem_read) begin
            if (!mem_busy) begin
               mem_busy   = 1'b1;
               mem_cnt    = 0;
               mem_addr_r = bus.mem_address;
               req_log.push_back(bus.mem_address);
               cur_lat    = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end else begin
               chk16("addr_stable", bus.mem_address, mem_addr_r);
            end
            mem_cnt++;
            if (mem_cnt > cur_lat) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = memf(mem_addr_r);
               resp_addr     = mem_addr_r;
               mem_busy      = 1'b0;
            end else begin
               bus.mem_rdata = 16'($urandom);
            end
         end else if (mem_busy) begin
            chk1("read_held", bus.mem_read, 1'b1);
            mem_busy = 1'b0;
         end
      end
   end

   // Monitor: compares what the DUT presents against the expected stream.
   initial begin
      lc3b_word e, ew;
      rst_d = 1'b0; acc_d = 1'b0; resp_d = 1'b0; vld_d = 1'b0; redir_d = 1'b0; raddr_d = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk1("rst_mem_read", bus.mem_read, 1'b0);
            if (rst_d) begin
               chk1("rst_ir_valid", bus.ir_valid, 1'b0);
               chk16("rst_ir_out", bus.ir_out, 16'h0000);
               chk16("rst_ir_pc", bus.ir_pc, 16'h0000);
               chk16("rst_mem_address", bus.mem_address, 16'h3000);
            end
         end else begin
            if (rst_d) chk1("first_fetch_read", bus.mem_read, 1'b1);
            if (bus.mem_read) chk1("addr_aligned", bus.mem_address[0], 1'b0);
            if (acc_d) chk1("accept_refetch", bus.mem_read, 1'b1);
            if (lat_chk_en && resp_d && !vld_d && !redir_d) begin
               chk1("fetch_latency", bus.ir_valid, 1'b1);
               chk16("latency_pc", bus.ir_pc, raddr_d);
            end
`ifndef IR_PREFETCH_EN
            if (bus.ir_valid) chk1("hold_no_read", bus.mem_read, 1'b0);
`endif
            if (bus.ir_valid && !bus.redirect && exp_q.size() > 0) begin
               e  = exp_q[0];
               ew = memf(e);
               chk16("present_pc", bus.ir_pc, e);
               chk16("present_word", bus.ir_out, ew);
               chk16("present_opcode", {12'd0, bus.ir_opcode}, {12'd0, ew[15:12]});
            end
            if (bus.ir_valid && bus.ir_ready && !bus.redirect) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL accept_stream: got pc %h, expected no instruction at %0t", bus.ir_pc, $time);
               end else begin
                  void'(exp_q.pop_front());
               end
            end
         end
         rst_d   = rst;
         acc_d   = !rst && bus.ir_valid && bus.ir_ready && !bus.redirect;
         resp_d  = !rst && bus.mem_resp;
         vld_d   = bus.ir_valid;
         redir_d = bus.redirect;
         raddr_d = resp_addr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      lc3b_word rp;
      int       n0;
      rst             = 1'b1;
      bus.ir_ready    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      lat_chk_en      = 1'b1;
      mem_lat         = 2;
      push_stream(16'h3000);
      repeat (3) cyc();
      bus.ir_ready = 1'b1;
      rst          = 1'b0;

      // Sequential fetch from the reset PC.
      wait_reqs(3, "seq_reqs");
      if (req_log.size() >= 3) begin
         chk16("seq_addr0", req_log[0], 16'h3000);
         chk16("seq_addr1", req_log[1], 16'h3002);
         chk16("seq_addr2", req_log[2], 16'h3004);
      end

      // Consumer stall, then exactly one accept.
      bus.ir_ready = 1'b0;
      wait_for(0, "stall_valid");
      repeat (5) cyc();
      n0 = req_log.size();
      bus.ir_ready = 1'b1;
      cyc();
      bus.ir_ready = 1'b0;
      wait_for(0, "after_stall_valid");
`ifndef IR_PREFETCH_EN
      chk16("one_fetch_after_ready", 16'(req_log.size()), 16'(n0 + 1));
`endif
      bus.ir_ready = 1'b1;
      lat_chk_en   = 1'b0;

      // Redirect one cycle into an outstanding read.
      mem_lat = 3;
      wait_for(1, "req_start");
      cyc();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h4001;
      push_stream(16'h4001);
      n0 = req_log.size();
      cyc();
      bus.redirect = 1'b0;
      wait_reqs(n0 + 1, "drain_reqs");
      if (req_log.size() > n0) chk16("redirect_addr", req_log[n0], 16'h4000);

      // Redirect in the same cycle as mem_resp.
      mem_lat = 2;
      wait_for(2, "resp_wait");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h5000;
      push_stream(16'h5000);
      n0 = req_log.size();
      cyc();
      bus.redirect = 1'b0;
      chk1("redir_resp_dropped", bus.ir_valid, 1'b0);
      wait_reqs(n0 + 1, "redir_resp_reqs");
      if (req_log.size() > n0) chk16("redir_resp_addr", req_log[n0], 16'h5000);

      // Redirect in the same cycle as an accept.
      wait_for(0, "hold_wait");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h6000;
      push_stream(16'h6000);
      n0 = req_log.size();
      cyc();
      bus.redirect = 1'b0;
      chk1("redir_accept_dropped", bus.ir_valid, 1'b0);
      wait_reqs(n0 + 1, "redir_accept_reqs");
      if (req_log.size() > n0) chk16("redir_accept_addr", req_log[n0], 16'h6000);

      // PC wrap at the top of the address space.
      mem_lat         = 1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      push_stream(16'hFFFE);
      n0 = req_log.size();
      cyc();
      bus.redirect = 1'b0;
      wait_reqs(n0 + 2, "wrap_reqs");
      if (req_log.size() > n0 + 1) begin
         chk16("wrap_addr0", req_log[n0], 16'hFFFE);
         chk16("wrap_addr1", req_log[n0 + 1], 16'h0000);
      end

      // Reset while draining.
      mem_lat = 3;
      wait_for(1, "drain_req_start");
      cyc();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h7000;
      push_stream(16'h7000);
      cyc();
      bus.redirect = 1'b0;
      rst          = 1'b1;
      cyc();
      chk1("drain_rst_read", bus.mem_read, 1'b0);
      chk1("drain_rst_valid", bus.ir_valid, 1'b0);
      cyc();
      push_stream(16'h3000);
      n0  = req_log.size();
      rst = 1'b0;
      wait_reqs(n0 + 1, "restart_reqs");
      if (req_log.size() > n0) chk16("restart_addr", req_log[n0], 16'h3000);

`ifdef IR_PREFETCH_EN
      // Accept from a filled prefetch entry keeps ir_valid high.
      mem_lat      = 1;
      bus.ir_ready = 1'b0;
      wait_for(0, "pf_valid_wait");
      repeat (4) cyc();
      bus.ir_ready = 1'b1;
      cyc();
      chk1("b2b_valid", bus.ir_valid, 1'b1);
`endif

      // Random traffic.
      mem_lat = 0;
      for (int i = 0; i < 3000; i++) begin
         bus.ir_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) begin
            rp              = 16'($urandom);
            bus.redirect    = 1'b1;
            bus.redirect_pc = rp;
            push_stream(rp);
         end else begin
            bus.redirect = 1'b0;
         end
         cyc();
      end
      bus.redirect = 1'b0;
      bus.ir_ready = 1'b0;
      repeat (5) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_fetch_ctrl.md
# ir_fetch_ctrl

Instruction-fetch controller for the LC-3b datapath. It sequences the instruction register:
- drives the memory read handshake at the current PC;
- loads the fetched word into its IR;
- presents the instruction and its opcode to the execute/control stage under a valid/ready handshake;
- handles control-flow redirects, including draining a read that is already in flight.

It sits between the unified memory port and the control FSM, upstream of the IR field decoder.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC of the first fetch after reset; bit 0 ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_address  out  16 (lc3b_word)  fetch address; bit 0 always 0
- mem_read  out  1  read request; held with a stable address until mem_resp
- mem_resp  in  1  one-cycle read completion
- mem_rdata  in  16 (lc3b_word)  read data, valid when mem_resp=1
- ir_out  out  16 (lc3b_word)  held instruction word
- ir_opcode  out  4 (lc3b_opcode)  ir_out[15:12]
- ir_pc  out  16  address ir_out was fetched from
- ir_valid  out  1  ir_out holds a live instruction
- ir_ready  in  1  consumer accepts ir_out this cycle
- redirect  in  1  discard the pipeline and fetch from redirect_pc
- redirect_pc  in  16  new fetch address; bit 0 forced to 0

## Operation

- State machine (lc3b_fetch_state):
  - FETCH: mem_read=1 at pc.
  - HOLD: ir_valid=1; waiting for ir_ready.
  - DRAIN: mem_read=1; the outstanding read will be discarded.
- FETCH + mem_resp, no redirect:
  - ir_out←mem_rdata, ir_pc←pc, pc←pc+2 (mod 2^16, wraps 16'hFFFE→16'h0000).
  - Next state HOLD.
- HOLD + ir_ready, no redirect: next state FETCH.
- FETCH + redirect, no mem_resp:
  - pc←redirect_pc. The request stays asserted at the old address (protocol: no retraction).
  - Next state DRAIN.
- FETCH + redirect + mem_resp in the same cycle: data discarded, pc←redirect_pc, next state FETCH.
- DRAIN + mem_resp: data discarded, next state FETCH at the new pc.
- DRAIN + redirect: pc←latest redirect_pc; stay in DRAIN unless mem_resp is also asserted, in which case go to FETCH.
- HOLD + redirect: pc←redirect_pc; the held instruction is dropped even if ir_ready=1. Next state FETCH.
- Priority: rst > redirect > mem_resp/ir_ready.

## Timing

- Values while rst=1 and on the cycle after the reset edge is observed:
  - state=FETCH, pc=RESET_PC.
  - ir_valid=0, ir_out=0, ir_pc=0.
  - mem_read forced to 0 while rst=1. mem_address=RESET_PC.
- First cycle with rst=0: mem_read=1.
- Fetch latency: mem_resp at cycle N → ir_valid=1 at N+1. No combinational path from mem_rdata to ir_out.
- Accept at cycle N (ir_valid & ir_ready) → mem_read=1 at N+1.
- Base throughput: one instruction per (memory latency + 2) cycles.
- ir_out, ir_pc and ir_opcode are stable while ir_valid=1 and not accepted.
- mem_read and mem_address are Moore outputs of state/pc. The address is stable for the whole request, including DRAIN.
- rst mid-request abandons the read. The memory is reset in the same cycle, system-wide.

## Configuration

- IR_PREFETCH_EN defined: adds a one-entry prefetch buffer (pf_word, pf_pc, pf_valid).
  - In HOLD with pf_valid=0, keep mem_read=1 at pc and fill the buffer on mem_resp.
  - On accept with pf_valid=1, the IR loads from the buffer at the same edge. ir_valid stays 1 (back-to-back issue), and the next fetch starts.
  - Redirect clears pf_valid. A prefetch read still outstanding goes through DRAIN.
  - Sustained rate with 1-cycle memory: one instruction every 2 cycles.
- IR_PREFETCH_EN undefined: no buffer, no fetch in HOLD, behaviour exactly as above.

## Structure

- lc3b_types gains:
  - the lc3b_fetch_state enum {FETCH, HOLD, DRAIN};
  - the constant LC3B_PC_STEP = 16'd2.
- Uses the existing lc3b_word and lc3b_opcode types.
- Sub-module fetch_buf (word/pc/valid register, load/clear), instantiated once for the IR. Under IR_PREFETCH_EN it is instantiated a second time for the prefetch entry.

## Test plan

- Reset, RESET_PC=16'h3000, memory latency 2, ir_ready=1:
  - mem_address sequence is 3000, 3002, 3004;
  - each ir_valid rises 1 cycle after mem_resp, with ir_pc matching.
- ir_ready=0 for 5 cycles while HOLD → ir_out and ir_pc stable, mem_read=0 (no prefetch build); exactly one fetch after ready.
- Redirect to 16'h4001 one cycle into an outstanding read:
  - mem_address stays at the old value until mem_resp;
  - that data is never presented;
  - next fetch address is 16'h4000.
- Redirect and mem_resp in the same cycle, and redirect and ir_ready in the same HOLD cycle → neither instruction is presented; next fetch at redirect_pc.
- pc=16'hFFFE fetch → next fetch address 16'h0000.
- Assert rst in DRAIN → ir_valid=0, mem_read=0; fetch restarts at RESET_PC. With IR_PREFETCH_EN and 1-cycle memory, verify back-to-back ir_valid across accepts.
